// File: rtl/ctrl_pkg.sv
// Shared control encodings for the pipelined RV32I front-end: opcodes, ALU ops,
// immediate/result select encodings, the NOP word and the ID/EX control record.
package ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} immsrc_t;
  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} resultsrc_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memwrite;
    resultsrc_t  resultsrc;
    logic [2:0]  aluctrl;
    logic        alusrc;
    immsrc_t     immsrc;
    logic        branch;
    logic        jump;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        illegal;
    logic [31:0] imm;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I subset decoder. CTRL_BRANCH_EXT_EN enables BLT/BGE/BLTU/BGEU.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        ill;
  immsrc_t     immsrc;
  logic [31:0] immext;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  // Immediate select is resolved apart from the main decode to keep ext32 out of a comb loop.
  always_comb begin
    case (opcode)
      OP_STORE:  immsrc = IMM_S;
      OP_BRANCH: immsrc = IMM_B;
      OP_JAL:    immsrc = IMM_J;
      default:   immsrc = IMM_I;
    endcase
  end

  ext32 u_ext (.instr(instr[31:7]), .immsrc(immsrc), .immext(immext));

  always_comb begin
    ctrl        = '0;
    ill         = 1'b0;
    ctrl.valid  = 1'b1;
    ctrl.rd     = instr[11:7];
    ctrl.funct3 = f3;
    ctrl.immsrc = immsrc;
    ctrl.imm    = immext;
    case (opcode)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        case (f3)
          3'b000:  ctrl.aluctrl = f7[5] ? ALU_SUB : ALU_ADD;
          3'b111:  ctrl.aluctrl = ALU_AND;
          3'b110:  ctrl.aluctrl = ALU_OR;
          3'b010:  ctrl.aluctrl = ALU_SLT;
          default: ill = 1'b1;
        endcase
        if (!(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b000))) ill = 1'b1;
      end
      OP_ITYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        case (f3)
          3'b000:  ctrl.aluctrl = ALU_ADD;
          3'b111:  ctrl.aluctrl = ALU_AND;
          3'b110:  ctrl.aluctrl = ALU_OR;
          3'b010:  ctrl.aluctrl = ALU_SLT;
          default: ill = 1'b1;
        endcase
      end
      OP_LOAD: begin
        ctrl.regwrite  = 1'b1;
        ctrl.alusrc    = 1'b1;
        ctrl.resultsrc = RES_MEM;
        ctrl.aluctrl   = ALU_ADD;
        if (f3 != 3'b010) ill = 1'b1;
      end
      OP_STORE: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluctrl  = ALU_ADD;
        if (f3 != 3'b010) ill = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.aluctrl = ALU_SUB;
`ifdef CTRL_BRANCH_EXT_EN
        if (f3[2:1] == 2'b01) ill = 1'b1;
`else
        if (f3[2:1] != 2'b00) ill = 1'b1;
`endif
      end
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.regwrite  = 1'b1;
        ctrl.resultsrc = RES_PC4;
        ctrl.aluctrl   = ALU_SUB;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
  end
endmodule

// File: rtl/ext32.sv
// Sign-extends the I/S/B/J immediate of an instruction to 32 bits.
module ext32
  import ctrl_pkg::*;
(
  input  logic [31:7] instr,
  input  immsrc_t     immsrc,
  output logic [31:0] immext
);
  always_comb begin
    case (immsrc)
      IMM_S:   immext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   immext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   immext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: immext = {{20{instr[31]}}, instr[31:20]};
    endcase
  end
endmodule

// File: rtl/rom.sv
// Combinational instruction ROM holding the boot image; unlisted words read as NOP.
module rom #(
  parameter int AW = 8
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);
  import ctrl_pkg::*;

  logic [31:0] idx;

  always_comb begin
    idx = 32'(addr);
    case (idx)
      32'd0:   data = 32'h0050_0093; // addi x1,x0,5
      32'd1:   data = 32'h0020_8463; // beq  x1,x2,8
      32'd2:   data = 32'h0040_A183; // lw   x3,4(x1)
      32'd3:   data = 32'h0021_8233; // add  x4,x3,x2
      32'd4:   data = 32'h4020_82B3; // sub  x5,x1,x2
      32'd5:   data = 32'h0020_A623; // sw   x2,12(x1)
      32'd6:   data = 32'h0020_E463; // bltu x1,x2,8
      32'd7:   data = 32'h0100_00EF; // jal  x1,16
      32'd8:   data = 32'hFFF0_0393; // addi x7,x0,-1
      32'd9:   data = 32'h0020_A333; // slt  x6,x1,x2
      32'd10:  data = 32'h0000_007F; // unsupported opcode
      default: data = NOP;
    endcase
  end
endmodule

// File: rtl/control_pipe.sv
// Pipelined control front-end: ROM fetch, IF/ID, decode, ID/EX, E-stage branch resolve.
// CTRL_BRANCH_EXT_EN adds signed/unsigned ordering branches using lt_e/ltu_e.
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ROM_AW     = 8,
  parameter int ALUCTRL_W  = 3,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_f,
  input  logic                  stall,
  input  logic                  flush_ext,
  input  logic                  zero_e,
  input  logic                  lt_e,
  input  logic                  ltu_e,
  output logic                  valid_e,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic [1:0]            ResultSrc,
  output logic [ALUCTRL_W-1:0]  ALUctrl,
  output logic                  ALUsrc,
  output logic [1:0]            ImmSrc,
  output logic [31:0]           ImmExt,
  output logic [REG_AW-1:0]     rs1_d,
  output logic [REG_AW-1:0]     rs2_d,
  output logic [REG_AW-1:0]     rd_e,
  output logic                  illegal_e,
  output logic                  PCsrc
);
  logic [31:0] rom_data;
  logic [31:0] ifid;
  ctrl_t       dec;
  ctrl_t       idex;
  logic        cond;
  logic        flush;
  logic        unused_pc;

  assign unused_pc = ^{pc_f[ADDR_WIDTH-1:ROM_AW+2], pc_f[1:0]};

  rom #(.AW(ROM_AW)) u_rom (.addr(pc_f[ROM_AW+1:2]), .data(rom_data));

  ctrl_decode u_dec (.instr(ifid), .ctrl(dec));

  assign flush = PCsrc | flush_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ifid <= NOP;
    else if (flush)  ifid <= NOP;
    else if (!stall) ifid <= rom_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 idex <= '0;
    else if (flush || stall) idex <= '0;
    else                     idex <= dec;
  end

`ifdef CTRL_BRANCH_EXT_EN
  always_comb begin
    case (idex.funct3)
      3'b000:  cond = zero_e;
      3'b001:  cond = !zero_e;
      3'b100:  cond = lt_e;
      3'b101:  cond = !lt_e;
      3'b110:  cond = ltu_e;
      3'b111:  cond = !ltu_e;
      default: cond = 1'b0;
    endcase
  end
`else
  logic unused_br;
  assign unused_br = ^{lt_e, ltu_e, idex.funct3[2:1]};
  // Only BEQ/BNE survive decode, so funct3[0] alone selects the polarity.
  assign cond = zero_e ^ idex.funct3[0];
`endif

  assign PCsrc     = idex.valid & (idex.jump | (idex.branch & cond));
  assign valid_e   = idex.valid;
  assign RegWrite  = idex.regwrite;
  assign MemWrite  = idex.memwrite;
  assign ResultSrc = idex.resultsrc;
  assign ALUctrl   = ALUCTRL_W'(idex.aluctrl);
  assign ALUsrc    = idex.alusrc;
  assign ImmSrc    = idex.immsrc;
  assign ImmExt    = idex.imm;
  assign rd_e      = REG_AW'(idex.rd);
  assign illegal_e = idex.illegal;
  assign rs1_d     = REG_AW'(ifid[19:15]);
  assign rs2_d     = REG_AW'(ifid[24:20]);
endmodule
